uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UartT transmitter between N byte-producing requesters using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake, then drives UartT `data_i`/`en_i`.
- Tracks UartT `busy_o` through a full frame and enforces an optional inter-frame gap.
- Sits between SoC byte sources (debug printer, loopback test generator, etc.) and the uart0 instance. It replaces the free-running counter feed on `data_i`/`en_i`.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 16, max cycles to wait for `uart_busy_i` to rise after the launch pulse (≥2).
- GAP_CYCLES, 0, idle cycles inserted after `busy` falls before the next grant (0..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  N  per-requester byte valid.
- req_data_i  input  8*N  byte of requester k at bits [8k+7:8k].
- req_ready_o  output  N  one-hot accept strobe; transfer when valid&ready.
- uart_data_o  output  8  to UartT `data_i`.
- uart_en_o  output  1  to UartT `en_i`, single-cycle launch pulse.
- uart_busy_i  input  1  from UartT `busy_o`.
- grant_id_o  output  clog2(N)  index of requester owning the current frame.
- active_o  output  1  high in any state other than IDLE.
- err_timeout_o  output  1  sticky: UartT failed to assert busy within TIMEOUT.
- err_clr_i  input  1  synchronous clear of err_timeout_o.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, rr_ptr=0.
  - uart_data_o=8'h00, uart_en_o=0, grant_id_o=0, active_o=0, err_timeout_o=0.
  - req_ready_o=0, gap and timeout counters=0.
- Reset mid-frame aborts the frame immediately. No byte is replayed.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If `uart_busy_i`=0 and any valid, select g = first k with req_valid_i[k]=1, searching k=rr_ptr, rr_ptr+1, … mod N.
  - req_ready_o is combinational: req_ready_o = onehot(g) in the same cycle. It depends on valid; requesters must not make valid depend on ready.
  - Valid must hold, with data stable, until ready.
  - On the accept edge:
    - uart_data_o <= byte g
    - grant_id_o <= g
    - rr_ptr <= (g+1) mod N
    - go to LAUNCH.
  - If `uart_busy_i`=1 in IDLE (foreign/stale frame), stay in IDLE with no grant.
- LAUNCH: uart_en_o=1 for exactly this one cycle; go to WAIT_BUSY, tcnt=0.
- WAIT_BUSY:
  - `uart_busy_i`=1 → go to WAIT_DONE.
  - Otherwise tcnt increments. When tcnt reaches TIMEOUT-1: err_timeout_o <= 1, go to IDLE (byte dropped).
- WAIT_DONE: when `uart_busy_i`=0 → go to GAP with gcnt=0 if GAP_CYCLES>0, else go to IDLE.
- GAP: gcnt increments; when gcnt reaches GAP_CYCLES-1 → go to IDLE.
- Latency: accept at cycle t, uart_en_o at t+1, earliest next accept at (busy-fall cycle)+1+GAP_CYCLES.
- req_ready_o=0 outside IDLE. uart_data_o and grant_id_o hold stable from accept until the next accept.
- rr_ptr wrap-around:
  - g=N-1 → rr_ptr=0.
  - A lone active requester is granted back-to-back.
  - Starvation bound: N-1 frames.
- err_clr_i:
  - Clears the flag next cycle.
  - If clear and a new timeout coincide in the same cycle, set wins.
- Counters sized clog2(TIMEOUT) and 8 bits. No overflow possible.

Test Plan:
- All four requesters valid continuously (bytes 8'hA0, 8'hB1, 8'hC2, 8'hD3), UartT model busy for 10 cycles starting 1 cycle after en → grant order 0,1,2,3,0. uart_data_o follows A0,B1,C2,D3,A0. Exactly one en pulse per frame.
- Only requester 2 valid, GAP_CYCLES=3 → back-to-back grants to 2. Next req_ready_o[2] occurs exactly 4 cycles after busy falls.
- UartT model never raises busy, TIMEOUT=16 → err_timeout_o=1 sixteen cycles after the en pulse. FSM returns to IDLE and grants the next requester. err_clr_i pulse → flag 0.
- Requesters 1 and 3 valid, rr_ptr=2 → grant 3 first, then 1, then 3 (wrap-around). Requester 1 valid alone raised mid-frame → its byte is not accepted until IDLE.
- rst_n asserted during WAIT_DONE → all outputs return to reset values asynchronously. After release with requester 0 valid, grant 0 happens on the first cycle busy=0.
- uart_busy_i held 1 in IDLE with requester 0 valid → no ready and no en until busy drops; then accept occurs in that same cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between N byte sources
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid_i,
    input  logic [8*N-1:0]       req_data_i,
    output logic [N-1:0]         req_ready_o,
    output logic [7:0]           uart_data_o,
    output logic                 uart_en_o,
    input  logic                 uart_busy_i,
    output logic [$clog2(N)-1:0] grant_id_o,
    output logic                 active_o,
    output logic                 err_timeout_o,
    input  logic                 err_clr_i
);

    localparam int             IDW       = $clog2(N);
    localparam int             TW        = $clog2(TIMEOUT);
    localparam logic [IDW:0]   N_W       = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
    // The counter is compared before it increments, so the last
    // idle WAIT_BUSY cycle is the one holding TIMEOUT-2.
    localparam logic [TW-1:0]  TCNT_LAST = TW'(TIMEOUT - 2);
    localparam logic [7:0]     GCNT_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant;
    logic [7:0]     r_data;
    logic [TW-1:0]  r_tcnt;
    logic [7:0]     r_gcnt;
    logic           r_err;

    logic           w_any;
    logic [IDW-1:0] w_sel;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_accept;
    logic           w_timeout;

    // Round-robin pick: first valid requester at or after r_rr_ptr, wrapping at N.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            w_idx = (w_sum >= N_W) ? IDW'(w_sum - N_W) : IDW'(w_sum);
            if (!w_any && req_valid_i[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state decode plus the accept and timeout strobes.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A busy transmitter in IDLE belongs to someone else; never grant over it.
                if (!uart_busy_i && w_any) begin
                    w_accept = 1'b1;
                    w_next   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy_i) begin
                    w_next = ST_WAIT_DONE;
                end else if (r_tcnt == TCNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy_i) begin
                    w_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gcnt == GCNT_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the granted byte, owner and pointer; run the frame counters and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_data   <= 8'h00;
            r_tcnt   <= '0;
            r_gcnt   <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data   <= req_data_i[{w_sel, 3'b000} +: 8];
                r_grant  <= w_sel;
                r_rr_ptr <= (w_sel == LAST_ID) ? '0 : w_sel + 1'b1;
            end

            if (r_state == ST_LAUNCH) begin
                r_tcnt <= '0;
            end else if (r_state == ST_WAIT_BUSY && !uart_busy_i) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (r_state == ST_WAIT_DONE) begin
                r_gcnt <= 8'h00;
            end else if (r_state == ST_GAP) begin
                r_gcnt <= r_gcnt + 8'h01;
            end

            // A timeout landing in the same cycle as a clear keeps the flag set.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    // Ready is a same-cycle strobe; forced low while reset is applied.
    assign req_ready_o   = (w_accept && rst_n) ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign uart_data_o   = r_data;
    assign grant_id_o    = r_grant;
    assign uart_en_o     = (r_state == ST_LAUNCH);
    assign active_o      = (r_state != ST_IDLE);
    assign err_timeout_o = r_err;

endmodule
